// File: rtl/int_sched.sv
// Interrupt scheduler for the CP0 block: latches and arbitrates three interrupt
// sources, waits for a retire point, emits the entry strobes, and tracks nested levels.
module int_sched #(
    parameter logic [31:0] VEC_BASE      = 32'h0000_0800,
    parameter logic [31:0] VEC_STRIDE    = 32'h0000_0010,
    parameter int          DRAIN_TIMEOUT = 8
) (
    input  logic        in_clk,
    input  logic        in_RST,
    input  logic [2:0]  in_irq,
    input  logic        in_IE,
    input  logic [3:0]  in_INM,
    input  logic        in_wb_valid,
    input  logic        in_eret,
    output logic        out_BK,
    output logic        out_NIE,
    output logic        out_redirect,
    output logic [31:0] out_vector,
    output logic [2:0]  out_pending,
    output logic [1:0]  out_level,
    output logic        out_fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ENTER = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  irq_q;
    logic [2:0]  pend;
    logic [1:0]  level;
    logic [1:0]  sel;
    logic [1:0]  sp;
    logic [7:0]  drain_cnt;
    logic        bk_q;
    logic [31:0] vector_q;
    logic        fault_q;
    logic [1:0]  stack [3];

    logic [2:0]  irq_edge;
    logic [2:0]  eligible;
    logic        any_eligible;
    logic [1:0]  winner;
    logic [1:0]  stack_top;
    logic [2:0]  pend_clr;
    logic [2:0]  pend_next;
    logic [31:0] sel_vector;
    logic        drain_abort;
    logic        drain_expired;

    // NOTE: every always_comb output gets a default assignment first so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        eligible = 3'b000;
        winner   = 2'd0;
        for (int i = 0; i < 3; i++) begin
            eligible[i] = pend[i] && !in_INM[i] && (3'(i + 1) > {1'b0, level});
        end
        if (eligible[2]) begin
            winner = 2'd2;
        end else if (eligible[1]) begin
            winner = 2'd1;
        end
    end

    assign any_eligible = |eligible;
    assign irq_edge     = in_irq & ~irq_q;

    // A new edge in the same cycle as the ENTER clear wins, so edges are OR-ed in last.
    assign pend_clr  = (state == ENTER) ? (3'b001 << sel) : 3'b000;
    assign pend_next = (pend & ~pend_clr) | irq_edge;

    assign stack_top     = (sp == 2'd0) ? 2'd0 : stack[sp - 2'd1];
    assign sel_vector    = VEC_BASE + 32'(sel) * VEC_STRIDE;
    assign drain_abort   = !in_IE || in_eret || in_INM[sel];
    assign drain_expired = (drain_cnt == 8'(DRAIN_TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge in_clk or posedge in_RST) begin
        if (in_RST) begin
            state     <= IDLE;
            irq_q     <= 3'b000;
            pend      <= 3'b000;
            level     <= 2'd0;
            sel       <= 2'd0;
            sp        <= 2'd0;
            drain_cnt <= 8'd0;
            bk_q      <= 1'b0;
            vector_q  <= 32'd0;
            fault_q   <= 1'b0;
        end else begin
            irq_q    <= in_irq;
            pend     <= pend_next;
            bk_q     <= 1'b0;
            vector_q <= 32'd0;
            case (state)
                IDLE: begin
                    if (in_eret) begin
                        if (sp == 2'd0) begin
                            fault_q <= 1'b1;
                        end else begin
                            level <= stack_top;
                            sp    <= sp - 2'd1;
                        end
                    end else if (in_IE && any_eligible) begin
                        sel       <= winner;
                        drain_cnt <= 8'd0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_abort) begin
                        state <= IDLE;
                    end else if (in_wb_valid || drain_expired) begin
                        // Strobes are registered here so they line up exactly with ENTER.
                        state    <= ENTER;
                        bk_q     <= 1'b1;
                        vector_q <= sel_vector;
                    end else begin
                        drain_cnt <= drain_cnt + 8'd1;
                    end
                end
                ENTER: begin
                    sp    <= sp + 2'd1;
                    level <= sel + 2'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the level stack is not reset; sp gates every read, so stale
    // entries are never observed before they are written.
    always_ff @(posedge in_clk) begin
        if (state == ENTER) begin
            stack[sp] <= level;
        end
    end

    assign out_BK       = bk_q;
    assign out_NIE      = bk_q;
    assign out_redirect = bk_q;
    assign out_vector   = vector_q;
    assign out_pending  = pend;
    assign out_level    = level;
    assign out_fault    = fault_q;

endmodule
